// File: rtl/root_fanout_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : root_fanout_dispatch
// Description : Root fan-out stage. Accepts one valid/ready transaction
//               stream and distributes it over NUM_CHILD child lanes. Each
//               lane has its own FIFO and valid/ready handshake. A lane is
//               chosen round-robin (MODE 0) or lowest-index-first (MODE 1)
//               among lanes that are not full.
// Ports       : clk, rst            clock, async active-high reset
//               enable              gate for input acceptance
//               in_valid/in_ready/in_data     upstream stream
//               out_valid/out_ready/out_data  per-lane streams (packed)
//               lane_count          per-lane occupancy (packed, CW each)
//               lane_full           per-lane occupancy == LANE_DEPTH
//               rr_ptr              next round-robin start lane
//               dispatched_total    running count of accepted inputs
// Revision    : 1.0  initial release
// ============================================================================
module root_fanout_dispatch #(
    parameter int NUM_CHILD  = 5,
    parameter int DATA_W     = 32,
    parameter int LANE_DEPTH = 4,
    parameter int MODE       = 0,
    parameter int CW         = $clog2(LANE_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic [NUM_CHILD-1:0]        out_valid,
    input  logic [NUM_CHILD-1:0]        out_ready,
    output logic [NUM_CHILD*DATA_W-1:0] out_data,
    output logic [NUM_CHILD*CW-1:0]     lane_count,
    output logic [NUM_CHILD-1:0]        lane_full,
    output logic [$clog2(NUM_CHILD)-1:0] rr_ptr,
    output logic [31:0]                 dispatched_total
);

    localparam int c_sel_w = $clog2(NUM_CHILD);
    localparam int c_ptr_w = $clog2(LANE_DEPTH);

    logic [c_sel_w-1:0]   r_rr_ptr;
    logic [31:0]          r_dispatched_total;
    logic [NUM_CHILD-1:0] w_full;
    logic [NUM_CHILD-1:0] w_push;
    logic [NUM_CHILD-1:0] w_pop;
    logic [c_sel_w-1:0]   w_sel;
    logic                 w_any_free;
    logic                 w_accept;

    // Lane selection works only from registered occupancy, so a full lane
    // that is popping this cycle is still treated as full. Candidates are
    // scanned from the farthest to the nearest so the last hit wins, which
    // leaves the first non-full lane in search order selected.
    always_comb begin
        int w_idx;
        w_idx      = 0;
        w_sel      = '0;
        w_any_free = 1'b0;
        for (int k = NUM_CHILD - 1; k >= 0; k--) begin
            if (MODE == 1) begin
                w_idx = k;
            end else begin
                w_idx = (int'(r_rr_ptr) + k) % NUM_CHILD;
            end
            if (!w_full[w_idx]) begin
                w_sel      = c_sel_w'(w_idx);
                w_any_free = 1'b1;
            end
        end
    end

    assign in_ready = enable & ~rst & w_any_free;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr           <= '0;
            r_dispatched_total <= '0;
        end else if (w_accept) begin
            r_dispatched_total <= r_dispatched_total + 32'd1;
            if (MODE == 0) begin
                r_rr_ptr <= (w_sel == c_sel_w'(NUM_CHILD - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    assign rr_ptr           = r_rr_ptr;
    assign dispatched_total = r_dispatched_total;

    generate
        for (genvar i = 0; i < NUM_CHILD; i++) begin : g_lane
            logic [DATA_W-1:0]  r_mem [LANE_DEPTH];
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_ptr_w-1:0] r_rd_ptr;
            logic [CW-1:0]      r_count;

            assign w_full[i] = (r_count == CW'(LANE_DEPTH));
            assign w_push[i] = w_accept && (w_sel == c_sel_w'(i));
            // out_valid gates the pop, so an empty lane can never underflow.
            assign w_pop[i]  = (r_count != '0) && out_ready[i];

            // Pointers wrap naturally because LANE_DEPTH is a power of two.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[i]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[i]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    r_count <= r_count + CW'(w_push[i]) - CW'(w_pop[i]);
                end
            end

            // Payload storage needs no reset: out_valid masks stale entries.
            always_ff @(posedge clk) begin
                if (w_push[i]) begin
                    r_mem[r_wr_ptr] <= in_data;
                end
            end

            assign out_valid[i]                 = (r_count != '0);
            assign out_data[i*DATA_W +: DATA_W] = r_mem[r_rd_ptr];
            assign lane_count[i*CW +: CW]       = r_count;
            assign lane_full[i]                 = w_full[i];
        end
    endgenerate

endmodule
`default_nettype wire
